decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the core, directly downstream of instruction fetch. Accepts one 32-bit RV32I instruction and its PC per cycle and decodes register indices, function fields and the sign-extended immediate. It presents a registered decoded bundle to execute under a valid/ready handshake. A two-entry skid buffer absorbs execute back-pressure, and a registered stall is raised toward fetch.

## Interface
- No parameters. Widths come from params.v: `INSTR_SIZE` and `ADDR_SIZE` are both 31, giving 32-bit buses.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr  in  32  instruction from fetch
- PC  in  32  PC of instr
- pipeline_valid  in  1  instr/PC valid this cycle
- stall  out  1  registered; fetch must hold its current instruction
- flush  in  1  synchronous kill from execute
- ex_ready  in  1  execute accepts the bundle this cycle
- dec_valid  out  1  decoded bundle valid
- dec_PC  out  32  PC of bundle
- dec_instr  out  32  raw instruction
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- imm  out  32  sign-extended immediate
- op_class  out  11  one-hot: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM
- rd_wen  out  1  instruction writes rd, and rd != 0
- illegal  out  1  unrecognised encoding

## Operation
- **Storage.** Output register OUT plus a skid register SKID, each holding the full decoded bundle.
- **States.**
  - EMPTY: OUT invalid.
  - ONE: OUT valid, SKID empty.
  - TWO: both valid.
- **Accept.** accept = pipeline_valid & !stall. Decoding is combinational on the input and is registered on accept.
- **Transitions** (no flush):
  - EMPTY + accept -> ONE, new bundle written into OUT.
  - ONE + ex_ready + accept -> ONE, OUT replaced.
  - ONE + ex_ready + no accept -> EMPTY.
  - ONE + !ex_ready + accept -> TWO, new bundle written into SKID.
  - TWO + ex_ready -> ONE, SKID moves to OUT. No accept is possible, since stall = 1.
  - TWO + !ex_ready -> TWO, hold.
- **Stall register.** stall <= next_state == TWO. It is asserted the cycle after SKID fills and drops the cycle after SKID drains. SKID covers the one instruction already in flight while stall propagates.
- **Flush.** flush has priority over everything:
  - next state is EMPTY and dec_valid = 0 on the following cycle;
  - SKID is invalidated and stall is cleared;
  - any instruction presented in the same cycle is discarded.
- **Decode rules.**
  - op_class comes from instr[6:0]: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
  - illegal = 1 when instr[1:0] != 2'b11 or the opcode is not in that list. Illegal bundles still flow through with op_class = 0, rd_wen = 0 and imm = 0.
  - imm formats:
    - I-type (JALR, LOAD, OP_IMM, SYSTEM): {20{i[31]}}, i[31:20]
    - S-type: {20{i[31]}}, i[31:25], i[11:7]
    - B-type: {19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0
    - U-type: i[31:12], 12'b0
    - J-type: {11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0
    - OP and MISC_MEM: 0
  - rd_wen = (LUI | AUIPC | JAL | JALR | LOAD | OP_IMM | OP | SYSTEM) & (rd != 0).

## Timing
- **Reset.** While reset = 0, regardless of clk: state EMPTY, stall = 0, dec_valid = 0, and every bundle field is 0, including illegal = 0.
- **Latency.** Accepted at edge N -> visible on the dec_* outputs after edge N, with throughput of one instruction per cycle while ex_ready = 1.
- **Handshake.** A bundle transfers at an edge where dec_valid & ex_ready. While ex_ready = 0, dec_* outputs stay stable.
- **Ordering.** Bundles leave in program order; SKID is never bypassed.
- **Reset mid-operation.** Both entries are dropped immediately. After release the stage starts in EMPTY.
- **flush with ex_ready in the same cycle.** The transfer of OUT still counts to execute, and the flush empties the stage afterwards.

## Test plan
- **I-type decode.** Reset release, then instr 0xFFF10093 (addi x1,x2,-1), PC 0x100, one cycle -> next cycle:
  - dec_valid = 1, dec_PC = 0x100;
  - rd = 1, rs1 = 2, imm = 0xFFFFFFFF;
  - op_class = OP_IMM, rd_wen = 1.
- **B- and U-type immediates.**
  - 0xFE208EE3 (beq x1,x2,-4) -> imm = 0xFFFFFFFC, BRANCH, rd_wen = 0.
  - 0x123452B7 (lui x5,0x12345) -> imm = 0x12345000, rd = 5.
- **Back-pressure.** Stream PCs 0x0, 0x4, 0x8… with ex_ready = 0 from cycle 2:
  - OUT holds 0x0 and SKID takes 0x4;
  - stall = 1 one cycle later;
  - after ex_ready = 1, execute sees 0x0, 0x4, 0x8 in order with no loss or duplication, and stall drops after one transfer.
- **Flush while full.** In state TWO, assert flush with pipeline_valid = 1 -> next cycle dec_valid = 0 and stall = 0, and the next accepted bundle is the one after flush.
- **Illegal and x0 destination.**
  - instr 0x00000000 -> illegal = 1, op_class = 0, rd_wen = 0.
  - 0x00000013 (addi x0,x0,0) -> illegal = 0, rd_wen = 0.
- **Asynchronous reset.** Reset asserted mid-cycle in state TWO -> dec_valid and stall go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with a two-entry skid buffer
// toward execute and a registered stall toward fetch.

package decode_pkg;

    localparam int INSTR_SIZE = 31;
    localparam int ADDR_SIZE  = 31;

    localparam int OC_LUI      = 0;
    localparam int OC_AUIPC    = 1;
    localparam int OC_JAL      = 2;
    localparam int OC_JALR     = 3;
    localparam int OC_BRANCH   = 4;
    localparam int OC_LOAD     = 5;
    localparam int OC_STORE    = 6;
    localparam int OC_OP_IMM   = 7;
    localparam int OC_OP       = 8;
    localparam int OC_MISC_MEM = 9;
    localparam int OC_SYSTEM   = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_SIZE:0]  pc;
        logic [INSTR_SIZE:0] instr;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [31:0]         imm;
        logic [10:0]         op_class;
        logic                rd_wen;
        logic                illegal;
    } id_ex_t;

endpackage

module decode_stage
    import decode_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_SIZE:0] instr,
    input  logic [ADDR_SIZE:0]  PC,
    input  logic                pipeline_valid,
    output logic                stall,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                dec_valid,
    output logic [ADDR_SIZE:0]  dec_PC,
    output logic [INSTR_SIZE:0] dec_instr,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [2:0]          funct3,
    output logic [6:0]          funct7,
    output logic [31:0]         imm,
    output logic [10:0]         op_class,
    output logic                rd_wen,
    output logic                illegal
);

    state_t state, state_n;
    id_ex_t dec, out_q, out_n, skid_q, skid_n;
    logic   stall_q;
    logic   accept;

    assign accept = pipeline_valid & ~stall_q;

    // Combinational decode of the incoming instruction
    always_comb begin
        dec          = '0;
        dec.pc       = PC;
        dec.instr    = instr;
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.funct3   = instr[14:12];
        dec.funct7   = instr[31:25];
        unique case (instr[6:0])
            7'b0110111: dec.op_class[OC_LUI]      = 1'b1;
            7'b0010111: dec.op_class[OC_AUIPC]    = 1'b1;
            7'b1101111: dec.op_class[OC_JAL]      = 1'b1;
            7'b1100111: dec.op_class[OC_JALR]     = 1'b1;
            7'b1100011: dec.op_class[OC_BRANCH]   = 1'b1;
            7'b0000011: dec.op_class[OC_LOAD]     = 1'b1;
            7'b0100011: dec.op_class[OC_STORE]    = 1'b1;
            7'b0010011: dec.op_class[OC_OP_IMM]   = 1'b1;
            7'b0110011: dec.op_class[OC_OP]       = 1'b1;
            7'b0001111: dec.op_class[OC_MISC_MEM] = 1'b1;
            7'b1110011: dec.op_class[OC_SYSTEM]   = 1'b1;
            default:    dec.op_class              = '0;
        endcase
        // every listed opcode ends in 2'b11, so a zero class covers both cases
        dec.illegal = ~|dec.op_class;
        unique case (1'b1)
            dec.op_class[OC_JALR],
            dec.op_class[OC_LOAD],
            dec.op_class[OC_OP_IMM],
            dec.op_class[OC_SYSTEM]:
                dec.imm = {{20{instr[31]}}, instr[31:20]};
            dec.op_class[OC_STORE]:
                dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec.op_class[OC_BRANCH]:
                dec.imm = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            dec.op_class[OC_LUI],
            dec.op_class[OC_AUIPC]:
                dec.imm = {instr[31:12], 12'b0};
            dec.op_class[OC_JAL]:
                dec.imm = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
            default:
                dec.imm = '0;
        endcase
        dec.rd_wen = (dec.op_class[OC_LUI]    | dec.op_class[OC_AUIPC] |
                      dec.op_class[OC_JAL]    | dec.op_class[OC_JALR]  |
                      dec.op_class[OC_LOAD]   | dec.op_class[OC_OP_IMM] |
                      dec.op_class[OC_OP]     | dec.op_class[OC_SYSTEM]) &
                     (|instr[11:7]);
    end

    // Occupancy next-state and register loads; flush wins over everything
    always_comb begin
        state_n = state;
        out_n   = out_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = ONE;
                        out_n   = dec;
                    end
                end
                ONE: begin
                    if (ex_ready) begin
                        if (accept) begin
                            out_n = dec;
                        end else begin
                            state_n = EMPTY;
                        end
                    end else if (accept) begin
                        state_n = TWO;
                        skid_n  = dec;
                    end
                end
                TWO: begin
                    if (ex_ready) begin
                        state_n = ONE;
                        out_n   = skid_q;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // State, bundle storage and the stall seen by fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_n;
            out_q   <= out_n;
            skid_q  <= skid_n;
            stall_q <= (state_n == TWO);
        end
    end

    assign stall     = stall_q;
    assign dec_valid = (state != EMPTY);
    assign dec_PC    = out_q.pc;
    assign dec_instr = out_q.instr;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign funct3    = out_q.funct3;
    assign funct7    = out_q.funct7;
    assign imm       = out_q.imm;
    assign op_class  = out_q.op_class;
    assign rd_wen    = out_q.rd_wen;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a scoreboard
// of accepted instructions checked as execute takes them.

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] PC = '0;
    logic        pipeline_valid = 1'b0;
    logic        stall;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_PC;
    logic [31:0] dec_instr;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [10:0] op_class;
    logic        rd_wen;
    logic        illegal;

    localparam logic [10:0] C_LUI    = 11'h001;
    localparam logic [10:0] C_BRANCH = 11'h010;
    localparam logic [10:0] C_OP_IMM = 11'h080;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    item_t q[$];
    int    tests = 0;
    int    fails = 0;

    decode_stage dut (
        .clk            (clk),
        .reset          (reset),
        .instr          (instr),
        .PC             (PC),
        .pipeline_valid (pipeline_valid),
        .stall          (stall),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .dec_valid      (dec_valid),
        .dec_PC         (dec_PC),
        .dec_instr      (dec_instr),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct3         (funct3),
        .funct7         (funct7),
        .imm            (imm),
        .op_class       (op_class),
        .rd_wen         (rd_wen),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference decode: {imm, op_class, rd_wen, illegal}
    function automatic logic [44:0] ref_dec(input logic [31:0] i);
        logic [10:0] oc;
        logic [31:0] im;
        byte         f;
        logic        wen;
        oc = '0;
        f  = "N";
        case (i[6:0])
            7'h37: begin oc = 11'h001; f = "U"; end
            7'h17: begin oc = 11'h002; f = "U"; end
            7'h6F: begin oc = 11'h004; f = "J"; end
            7'h67: begin oc = 11'h008; f = "I"; end
            7'h63: begin oc = 11'h010; f = "B"; end
            7'h03: begin oc = 11'h020; f = "I"; end
            7'h23: begin oc = 11'h040; f = "S"; end
            7'h13: begin oc = 11'h080; f = "I"; end
            7'h33: begin oc = 11'h100; f = "N"; end
            7'h0F: begin oc = 11'h200; f = "N"; end
            7'h73: begin oc = 11'h400; f = "I"; end
            default: begin oc = 11'h000; f = "N"; end
        endcase
        case (f)
            "I": im = {{20{i[31]}}, i[31:20]};
            "S": im = {{20{i[31]}}, i[31:25], i[11:7]};
            "B": im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            "U": im = {i[31:12], 12'b0};
            "J": im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: im = '0;
        endcase
        wen = (|(oc & 11'h5AF)) && (i[11:7] != 5'd0);
        return {im, oc, wen, (oc == 11'h000)};
    endfunction

    // one cycle: drive, score any transfer at the coming edge, advance
    task automatic tick(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic acc);
        item_t e;
        pipeline_valid = v;
        instr          = ins;
        PC             = pc;
        ex_ready       = rdy;
        flush          = fl;
        if (dec_valid && rdy) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_extra: observed PC %h expected none", dec_PC);
            end else begin
                e = q.pop_front();
                chk("xfer_pc", {dec_PC, dec_instr}, {e.pc, e.ins});
                chk("xfer_dec", {imm, op_class, rd_wen, illegal},
                    ref_dec(e.ins));
                chk("xfer_fields", {rd, rs1, rs2, funct3, funct7},
                    {e.ins[11:7], e.ins[19:15], e.ins[24:20],
                     e.ins[14:12], e.ins[31:25]});
            end
        end
        if (fl) q.delete();
        if (acc) q.push_back('{pc: pc, ins: ins});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_ctrl", {dec_valid, stall}, 2'b00);
        chk("rst_bus", {dec_PC, dec_instr}, 64'd0);
        chk("rst_fields", {imm, op_class, rd_wen, illegal, rd, rs1, rs2,
                           funct3, funct7}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // I-type
        tick(1, 32'hFFF10093, 32'h100, 1, 0, 1);
        chk("addi_valid_pc", {dec_valid, dec_PC}, {1'b1, 32'h100});
        chk("addi_regs", {rd, rs1}, {5'd1, 5'd2});
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_class", {op_class, rd_wen}, {C_OP_IMM, 1'b1});

        // B-type and U-type
        tick(1, 32'hFE208EE3, 32'h104, 1, 0, 1);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_class", {op_class, rd_wen}, {C_BRANCH, 1'b0});
        tick(1, 32'h123452B7, 32'h108, 1, 0, 1);
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_rd", {rd, op_class, rd_wen}, {5'd5, C_LUI, 1'b1});

        // illegal and x0 destination
        tick(1, 32'h00000000, 32'h10C, 1, 0, 1);
        chk("ill_zero", {illegal, op_class, rd_wen, imm},
            {1'b1, 11'd0, 1'b0, 32'd0});
        tick(1, 32'h00000013, 32'h110, 1, 0, 1);
        chk("nop_x0", {illegal, rd_wen}, 2'b00);
        tick(0, 32'h0, 32'h0, 1, 0, 0);
        chk("drain_empty", {dec_valid, stall}, 2'b00);

        // back-pressure: lw, sw, jal at 0x0, 0x4, 0x8
        tick(1, 32'h00412283, 32'h0, 1, 0, 1);
        tick(1, 32'hFE512C23, 32'h4, 0, 0, 1);
        chk("bp_hold_stall", {dec_valid, stall, dec_PC}, {2'b11, 32'h0});
        tick(1, 32'h008000EF, 32'h8, 0, 0, 0);
        chk("bp_stable", {dec_valid, stall, dec_PC}, {2'b11, 32'h0});
        tick(1, 32'h008000EF, 32'h8, 1, 0, 0);
        chk("bp_skid_move", {dec_valid, stall, dec_PC}, {2'b10, 32'h4});
        tick(1, 32'h008000EF, 32'h8, 1, 0, 1);
        chk("bp_third", {dec_valid, stall, dec_PC}, {2'b10, 32'h8});
        tick(0, 32'h0, 32'h0, 1, 0, 0);
        chk("bp_no_loss", q.size(), 64'd0);

        // flush while full, with a new instruction presented
        tick(1, 32'h00001117, 32'h200, 1, 0, 1);
        tick(1, 32'h00208033, 32'h204, 0, 0, 1);
        chk("fl_full", {dec_valid, stall}, 2'b11);
        tick(1, 32'h0000100F, 32'h208, 0, 1, 0);
        chk("fl_cleared", {dec_valid, stall}, 2'b00);
        tick(1, 32'h00000073, 32'h20C, 1, 0, 1);
        chk("fl_next", {dec_valid, dec_PC}, {1'b1, 32'h20C});
        tick(0, 32'h0, 32'h0, 1, 0, 0);
        chk("fl_drained", q.size(), 64'd0);

        // asynchronous reset mid-cycle while in TWO
        tick(1, 32'h00C00067, 32'h300, 1, 0, 1);
        tick(1, 32'h80000537, 32'h304, 0, 0, 1);
        chk("ar_full", {dec_valid, stall}, 2'b11);
        #3;
        pipeline_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("ar_async", {dec_valid, stall, dec_PC}, {2'b00, 32'h0});
        q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        tick(0, 32'h0, 32'h0, 1, 0, 0);
        chk("ar_restart", {dec_valid, stall}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
